// File: rtl/mulk_pkg.sv
// Shared defaults and helpers for the K-multiplier pipeline.
package mulk_pkg;

  localparam int DEF_A_W   = 16;
  localparam int DEF_B_W   = 20;
  localparam int DEF_P_W   = 30;
  localparam int DEF_SHIFT = 4;
  localparam int DEF_LAT   = 3;

  // Full-precision product width of an a_w x b_w unsigned multiply
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/mulk_round_sat.sv
// Combinational right shift, optional round-half-up and saturation to P_W bits.
// Build option: MULK_ROUND_EN adds 2^(SHIFT-1) before the shift.
module mulk_round_sat #(
  parameter int IN_W  = 36,
  parameter int SHIFT = 4,
  parameter int P_W   = 30
) (
  input  logic [IN_W-1:0] prod,
  output logic [P_W-1:0]  res,
  output logic            sat
);

`ifdef MULK_ROUND_EN
  // One extra bit so the rounding add cannot wrap
  localparam int SUM_W = IN_W + 1;
`else
  localparam int SUM_W = IN_W;
`endif

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] q;

`ifdef MULK_ROUND_EN
  if (SHIFT > 0) begin : g_round
    assign sum = SUM_W'(prod) + (SUM_W'(1) << (SHIFT - 1));
  end else begin : g_no_round
    assign sum = SUM_W'(prod);
  end
`else
  assign sum = prod;
`endif

  assign q = sum >> SHIFT;

  // Any bit above the result width means the value does not fit
  if (SUM_W > P_W) begin : g_sat
    assign sat = |q[SUM_W-1:P_W];
  end else begin : g_no_sat
    assign sat = 1'b0;
  end

  // Clamp to all ones on overflow, otherwise pass the low P_W bits
  always_comb begin
    res = P_W'(q);
    if (sat) res = '1;
  end

endmodule

// File: rtl/mul_k_pipe.sv
// Pipelined unsigned sample x K multiplier with valid/ready flow control,
// shift, saturation and a sticky saturation flag.
// Build option: MULK_ROUND_EN enables round-half-up before the shift.
module mul_k_pipe
  import mulk_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int P_W   = DEF_P_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int LAT   = DEF_LAT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] sqrt_poly_in,
  input  logic [B_W-1:0] co_k,
  input  logic           co_k_load,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] mid_mul_k,
  output logic           sat,
  output logic           sat_sticky,
  input  logic           sat_clr
);

  localparam int PROD_W = prod_width(A_W, B_W);

  logic              adv;
  logic [B_W-1:0]    coef;
  logic              s1_valid;
  logic [A_W-1:0]    s1_a;
  logic [B_W-1:0]    s1_k;
  logic [PROD_W-1:0] prod_c;
  logic [PROD_W-1:0] fin_prod;
  logic              fin_valid;
  logic [P_W-1:0]    rs_res;
  logic              rs_sat;

  // Global enable: the whole pipe moves unless the output is held
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Coefficient register loads regardless of stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         coef <= '0;
    else if (co_k_load) coef <= co_k;
  end

  // Stage 1: capture the sample with the K in force at accept (bypass on load)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_k     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_a     <= sqrt_poly_in;
      s1_k     <= co_k_load ? co_k : coef;
    end
  end

  assign prod_c = PROD_W'(s1_a) * PROD_W'(s1_k);

  if (LAT == 2) begin : g_direct
    // Multiply and round/saturate share the final stage
    assign fin_prod  = prod_c;
    assign fin_valid = s1_valid;
  end else begin : g_pipe
    localparam int unsigned NP = LAT - 2;
    logic [PROD_W-1:0] prod_q [NP];
    logic [NP-1:0]     pv;

    // Product stages 2..LAT-1; retiming spreads the multiplier across them
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
        for (int unsigned i = 0; i < NP; i++) prod_q[i] <= '0;
      end else if (adv) begin
        pv[0]     <= s1_valid;
        prod_q[0] <= prod_c;
        for (int unsigned i = 1; i < NP; i++) begin
          pv[i]     <= pv[i-1];
          prod_q[i] <= prod_q[i-1];
        end
      end
    end

    assign fin_prod  = prod_q[NP-1];
    assign fin_valid = pv[NP-1];
  end

  mulk_round_sat #(
    .IN_W  (PROD_W),
    .SHIFT (SHIFT),
    .P_W   (P_W)
  ) u_round_sat (
    .prod (fin_prod),
    .res  (rs_res),
    .sat  (rs_sat)
  );

  // Final stage: register the shifted, saturated result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      mid_mul_k <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      out_valid <= fin_valid;
      mid_mul_k <= rs_res;
      sat       <= rs_sat;
    end
  end

  // Sticky flag: set on a delivered saturated beat, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              sat_sticky <= 1'b0;
    else if (sat_clr)                        sat_sticky <= 1'b0;
    else if (out_valid && out_ready && sat)  sat_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_mul_k_pipe.sv
// Self-checking bench for mul_k_pipe: directed scenarios plus randomized
// traffic, compared against an arithmetic reference model and scoreboard.
`timescale 1ns/1ps
module tb_mul_k_pipe;
  import mulk_pkg::*;

  localparam int A_W   = DEF_A_W;
  localparam int B_W   = DEF_B_W;
  localparam int P_W   = DEF_P_W;
  localparam int SHIFT = DEF_SHIFT;
  localparam int LAT   = DEF_LAT;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] sqrt_poly_in;
  logic [B_W-1:0] co_k;
  logic           co_k_load;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] mid_mul_k;
  logic           sat;
  logic           sat_sticky;
  logic           sat_clr;

  always #5 clk = ~clk;

  mul_k_pipe #(
    .A_W   (A_W),
    .B_W   (B_W),
    .P_W   (P_W),
    .SHIFT (SHIFT),
    .LAT   (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sqrt_poly_in (sqrt_poly_in),
    .co_k         (co_k),
    .co_k_load    (co_k_load),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .mid_mul_k    (mid_mul_k),
    .sat          (sat),
    .sat_sticky   (sat_sticky),
    .sat_clr      (sat_clr)
  );

  typedef struct {
    logic [P_W-1:0] val;
    logic           sat;
  } exp_t;

  exp_t           exp_q[$];
  int             n_tests = 0;
  int             n_fail  = 0;
  logic [B_W-1:0] k_model;
  logic           sticky_model;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: full product, optional half-up rounding, shift, clamp
  function automatic exp_t model(input longint unsigned a, input longint unsigned k);
    longint unsigned p;
    longint unsigned q;
    exp_t e;
    p = a * k;
`ifdef MULK_ROUND_EN
    if (SHIFT > 0) p = p + (64'd1 << (SHIFT - 1));
`endif
    q = p >> SHIFT;
    if (q > ((64'd1 << P_W) - 1)) begin
      e.val = '1;
      e.sat = 1'b1;
    end else begin
      e.val = q[P_W-1:0];
      e.sat = 1'b0;
    end
    return e;
  endfunction

  // One clock: observe handshakes, update model, advance past the edge
  task automatic step(output logic acc);
    exp_t           e;
    logic           deliv;
    logic           stalled;
    logic [P_W-1:0] held_val;
    logic           held_sat;
    #1;
    check("in_ready", in_ready, !out_valid || out_ready);
    deliv    = out_valid && out_ready;
    acc      = in_valid && in_ready;
    stalled  = out_valid && !out_ready;
    held_val = mid_mul_k;
    held_sat = sat;
    e.sat    = 1'b0;
    if (deliv) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("mid_mul_k", mid_mul_k, e.val);
        check("sat", sat, e.sat);
      end
    end
    if (sat_clr)             sticky_model = 1'b0;
    else if (deliv && e.sat) sticky_model = 1'b1;
    if (acc) exp_q.push_back(model(sqrt_poly_in, co_k_load ? co_k : k_model));
    if (co_k_load) k_model = co_k;
    @(posedge clk);
    #1;
    check("sat_sticky", sat_sticky, sticky_model);
    if (stalled) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_mid_mul_k", mid_mul_k, held_val);
      check("hold_sat", sat, held_sat);
    end
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    co_k_load = 1'b0;
    sat_clr   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic drain();
    logic acc;
    idle_inputs();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(acc);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send(input logic [A_W-1:0] a, input logic load, input logic [B_W-1:0] k);
    logic acc;
    in_valid     = 1'b1;
    sqrt_poly_in = a;
    co_k_load    = load;
    co_k         = k;
    step(acc);
    check("send_accepted", acc, 1'b1);
    in_valid  = 1'b0;
    co_k_load = 1'b0;
  endtask

  task automatic stream(input logic [B_W-1:0] k);
    logic acc;
    int   a;
    int   i;
    idle_inputs();
    co_k      = k;
    co_k_load = 1'b1;
    step(acc);
    co_k_load = 1'b0;
    a = 1;
    i = 0;
    while (i < 80 && (a <= 8 || exp_q.size() > 0)) begin
      in_valid     = (a <= 8);
      sqrt_poly_in = A_W'(a);
      out_ready    = (i % 3 == 0);
      step(acc);
      if (acc) a++;
      i++;
    end
    check("stream_all_sent", a, 9);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic acc;
    rst_n        = 1'b0;
    sqrt_poly_in = '0;
    co_k         = '0;
    idle_inputs();
    k_model      = '0;
    sticky_model = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mid_mul_k", mid_mul_k, 0);
    check("rst_sat", sat, 1'b0);
    check("rst_sat_sticky", sat_sticky, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic and exact latency
    send(16'd1000, 1'b1, 20'd65536);
    check("lat_edge1", out_valid, 1'b0);
    step(acc);
    check("lat_edge2", out_valid, 1'b0);
    step(acc);
    check("lat_edge3", out_valid, 1'b1);
    check("basic_value", mid_mul_k, 4096000);
    drain();

    // Rounding
    send(16'd3, 1'b1, 20'd3);
    drain();

    // Saturation and sticky clear
    send(16'hFFFF, 1'b1, 20'hFFFFF);
    drain();
    check("sticky_set", sat_sticky, 1'b1);
    sat_clr = 1'b1;
    step(acc);
    sat_clr = 1'b0;
    check("sticky_cleared", sat_sticky, 1'b0);

    // Backpressure streams
    stream(20'd2);
    stream(20'd256);

    // Coefficient race
    send(16'd100, 1'b1, 20'd256);
    send(16'd100, 1'b1, 20'd512);
    drain();

    // Reset mid-operation
    out_ready = 1'b0;
    send(16'd5, 1'b0, '0);
    send(16'd6, 1'b0, '0);
    send(16'd7, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_mid_mul_k", mid_mul_k, 0);
    exp_q.delete();
    k_model      = '0;
    sticky_model = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      step(acc);
      check("post_rst_idle", out_valid, 1'b0);
    end
    send(16'd1000, 1'b1, 20'd65536);
    drain();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      in_valid     = ($urandom_range(3) != 0);
      out_ready    = ($urandom_range(3) != 0);
      co_k_load    = ($urandom_range(7) == 0);
      sat_clr      = ($urandom_range(15) == 0);
      sqrt_poly_in = ($urandom_range(3) == 0) ? '1 : A_W'($urandom);
      co_k         = ($urandom_range(3) == 0) ? '1 : B_W'($urandom);
      step(acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
